// File: rtl/ibex_lfsr_reseed_if.sv
// Purpose: bundles the control, seed, entropy and status signals of ibex_lfsr_reseed.
// Latency: none, wires only.
// Backpressure: entropy uses a req/ack handshake; req is held until a single-cycle ack.
// Ports (slave view): en_i, seed_valid_i, seed_i, reseed_i, entropy_ack_i, entropy_i in;
//                     entropy_req_o, lfsr_o, lockup_o, busy_o out.
interface ibex_lfsr_reseed_if #(
    parameter int unsigned LfsrW = 32
);
    logic             en_i;
    logic             seed_valid_i;
    logic [LfsrW-1:0] seed_i;
    logic             reseed_i;
    logic             entropy_req_o;
    logic             entropy_ack_i;
    logic [LfsrW-1:0] entropy_i;
    logic [LfsrW-1:0] lfsr_o;
    logic             lockup_o;
    logic             busy_o;

    // Driver side: CSR block, entropy source and consumer of the random stream.
    modport master (
        output en_i, seed_valid_i, seed_i, reseed_i, entropy_ack_i, entropy_i,
        input  entropy_req_o, lfsr_o, lockup_o, busy_o
    );

    // Generator side.
    modport slave (
        input  en_i, seed_valid_i, seed_i, reseed_i, entropy_ack_i, entropy_i,
        output entropy_req_o, lfsr_o, lockup_o, busy_o
    );
endinterface

// File: rtl/ibex_lfsr_reseed.sv
// Purpose: Galois LFSR with software seed load, periodic/manual entropy reseed and zero-lockup recovery.
// Latency: a step, seed load or merge becomes visible on lfsr_o one cycle later (two with IBEX_LFSR_PERM_EN).
// Backpressure: entropy_req_o is held until entropy_ack_i; stepping continues while waiting.
// Ports: clk_i, rst_ni (async, active-low), bus (ibex_lfsr_reseed_if.slave).
// Optional macro IBEX_LFSR_PERM_EN: lfsr_o = bitrev(state) ^ rotl(state, LfsrW/2), registered.
module ibex_lfsr_reseed #(
    parameter int unsigned      LfsrW          = 32,
    parameter logic [LfsrW-1:0] Taps           = 32'h80200003,
    parameter logic [LfsrW-1:0] DefaultSeed    = 32'hac533bf4,
    parameter int unsigned      ReseedInterval = 1024,
    parameter int unsigned      CntW           = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    ibex_lfsr_reseed_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fsm_e;

    localparam logic [CntW-1:0] RiCnt  = CntW'(ReseedInterval);
    localparam bit              AutoEn = (ReseedInterval != 0);

    fsm_e             r_fsm;
    fsm_e             w_fsm_nxt;
    logic [LfsrW-1:0] r_state;
    logic [LfsrW-1:0] w_state_nxt;
    logic [LfsrW-1:0] w_step;
    logic [LfsrW-1:0] w_cand;
    logic [CntW-1:0]  r_cnt;
    logic [CntW-1:0]  w_cnt_nxt;
    logic             r_lockup;
    logic             w_lockup_nxt;
    logic             w_ack;
    logic             w_load;
    logic             w_req;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_step = r_state >> 1;
        if (r_state[0]) begin
            w_step = w_step ^ Taps;
        end
    end

    // Ack only counts while a request is outstanding.
    assign w_ack  = (r_fsm == REQ) && bus.entropy_ack_i;
    assign w_load = bus.seed_valid_i | w_ack;

    // Seed wins over merge; a simultaneous ack is consumed but its entropy dropped.
    always_comb begin
        w_cand = r_state ^ bus.entropy_i;
        if (bus.seed_valid_i) begin
            w_cand = bus.seed_i;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_lockup_nxt = 1'b0;
        if (w_load) begin
            w_cnt_nxt = '0;
            // Zero is a fixed point of the LFSR, so it is never allowed in.
            if (w_cand == '0) begin
                w_state_nxt  = DefaultSeed;
                w_lockup_nxt = 1'b1;
            end else begin
                w_state_nxt  = w_cand;
            end
        end else if (bus.en_i) begin
            w_state_nxt = w_step;
            if (r_cnt < RiCnt) begin
                w_cnt_nxt = r_cnt + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= DefaultSeed;
            r_cnt    <= '0;
            r_lockup <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_lockup <= w_lockup_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Reseed FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // reseed_i is not queued while REQ is outstanding.
    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            IDLE: begin
                if (bus.reseed_i || (AutoEn && (r_cnt == RiCnt))) begin
                    w_fsm_nxt = REQ;
                end
            end
            REQ: begin
                if (bus.entropy_ack_i) begin
                    w_fsm_nxt = IDLE;
                end
            end
            default: w_fsm_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_req = 1'b0;
        if (r_fsm == REQ) begin
            w_req = 1'b1;
        end
    end

    assign bus.entropy_req_o = w_req;
    assign bus.busy_o        = w_req;
    assign bus.lockup_o      = r_lockup;

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
`ifdef IBEX_LFSR_PERM_EN
    function automatic logic [LfsrW-1:0] perm(input logic [LfsrW-1:0] s);
        logic [LfsrW-1:0] rev;
        for (int i = 0; i < LfsrW; i++) begin
            rev[i] = s[LfsrW-1-i];
        end
        return rev ^ ((s << (LfsrW/2)) | (s >> (LfsrW - LfsrW/2)));
    endfunction

    logic [LfsrW-1:0] r_out;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out <= perm(DefaultSeed);
        end else begin
            r_out <= perm(r_state);
        end
    end

    assign bus.lfsr_o = r_out;
`else
    assign bus.lfsr_o = r_state;
`endif

endmodule

// File: tb/tb_ibex_lfsr_reseed.sv
// Purpose: self-checking bench for ibex_lfsr_reseed (default build, ReseedInterval = 4).
// Latency: reference model updates once per clock, outputs sampled 1 time unit after posedge.
// Backpressure: entropy ack is driven directly by the bench.
module tb_ibex_lfsr_reseed;
    localparam int unsigned W     = 32;
    localparam logic [31:0] TAPS  = 32'h80200003;
    localparam logic [31:0] DSEED = 32'hac533bf4;
    localparam int          RI    = 4;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    ibex_lfsr_reseed_if #(.LfsrW(W)) bus ();

    ibex_lfsr_reseed #(
        .LfsrW         (W),
        .Taps          (TAPS),
        .DefaultSeed   (DSEED),
        .ReseedInterval(RI),
        .CntW          (16)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: abstract state of the generator.
    logic [31:0] m_state;
    int          m_steps_since;   // steps since last seed/merge, capped at RI
    bit          m_req;
    bit          m_lock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        if (s % 2 == 1) return (s / 2) ^ TAPS;
        return s / 2;
    endfunction

    task automatic model_reset();
        m_state       = DSEED;
        m_steps_since = 0;
        m_req         = 1'b0;
        m_lock        = 1'b0;
    endtask

    task automatic clear_inputs();
        bus.en_i          = 1'b0;
        bus.seed_valid_i  = 1'b0;
        bus.seed_i        = '0;
        bus.reseed_i      = 1'b0;
        bus.entropy_ack_i = 1'b0;
        bus.entropy_i     = '0;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_lfsr"},   64'(bus.lfsr_o),        64'(m_state));
        check_eq({tag, "_req"},    64'(bus.entropy_req_o), 64'(m_req));
        check_eq({tag, "_busy"},   64'(bus.busy_o),        64'(m_req));
        check_eq({tag, "_lockup"}, 64'(bus.lockup_o),      64'(m_lock));
    endtask

    // One clock with the currently driven inputs; model advanced from the rules.
    task automatic tick();
        logic [31:0] ns;
        int          nc;
        bit          nr;
        bit          nl;
        bit          took_ack;
        took_ack = m_req && bus.entropy_ack_i;
        ns = m_state;
        nc = m_steps_since;
        nl = 1'b0;
        if (bus.seed_valid_i || took_ack) begin
            ns = bus.seed_valid_i ? bus.seed_i : (m_state ^ bus.entropy_i);
            if (ns == 0) begin
                ns = DSEED;
                nl = 1'b1;
            end
            nc = 0;
        end else if (bus.en_i) begin
            ns = lfsr_step(m_state);
            if (nc < RI) nc++;
        end
        if (m_req) nr = !bus.entropy_ack_i;
        else       nr = bus.reseed_i || (m_steps_since == RI);
        @(posedge clk_i);
        #1;
        m_state       = ns;
        m_steps_since = nc;
        m_req         = nr;
        m_lock        = nl;
        check_outputs("cyc");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;
        logic [31:0] prev;

        clear_inputs();
        model_reset();

        // Reset state
        #12;
        check_outputs("reset");
        #10 rst_ni = 1'b1;
        tick();

        // Single default step
        bus.en_i = 1'b1;
        tick();
        clear_inputs();
        check_eq("t1_step", 64'(bus.lfsr_o), 64'h56299DFA);

        // Seed 1 then three steps
        bus.seed_valid_i = 1'b1;
        bus.seed_i       = 32'h1;
        tick();
        clear_inputs();
        check_eq("t2_seed", 64'(bus.lfsr_o), 64'h1);
        bus.en_i = 1'b1;
        tick(); check_eq("t2_s1", 64'(bus.lfsr_o), 64'h80200003);
        tick(); check_eq("t2_s2", 64'(bus.lfsr_o), 64'hC0300002);
        tick(); check_eq("t2_s3", 64'(bus.lfsr_o), 64'h60180001);
        clear_inputs();

        // Zero seed recovery
        bus.seed_valid_i = 1'b1;
        bus.seed_i       = 32'h0;
        tick();
        clear_inputs();
        check_eq("t3_zseed_lfsr", 64'(bus.lfsr_o), 64'(DSEED));
        check_eq("t3_zseed_lock", 64'(bus.lockup_o), 64'h1);
        tick();
        check_eq("t3_lock_clear", 64'(bus.lockup_o), 64'h0);

        // Zero merge recovery
        bus.seed_valid_i = 1'b1;
        bus.seed_i       = 32'h12345678;
        bus.reseed_i     = 1'b1;
        tick();
        clear_inputs();
        check_eq("t3_req_up", 64'(bus.entropy_req_o), 64'h1);
        bus.entropy_ack_i = 1'b1;
        bus.entropy_i     = 32'h12345678;
        tick();
        clear_inputs();
        check_eq("t3_zmerge_lfsr", 64'(bus.lfsr_o), 64'(DSEED));
        check_eq("t3_zmerge_lock", 64'(bus.lockup_o), 64'h1);
        check_eq("t3_req_down", 64'(bus.entropy_req_o), 64'h0);

        // Periodic reseed: counter hits RI, request follows one cycle later
        bus.en_i = 1'b1;
        n = 0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(); n++;
            if (bus.entropy_req_o) seen = 1'b1;
        end
        check_eq("t4_req_after", 64'(n), 64'(RI + 1));
        tick();
        tick();
        prev = m_state;
        bus.entropy_ack_i = 1'b1;
        bus.entropy_i     = 32'hFFFFFFFF;
        tick();
        bus.entropy_ack_i = 1'b0;
        check_eq("t4_merge", 64'(bus.lfsr_o), 64'(prev ^ 32'hFFFFFFFF));
        check_eq("t4_req_drop", 64'(bus.entropy_req_o), 64'h0);
        n = 0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(); n++;
            if (bus.entropy_req_o) seen = 1'b1;
        end
        check_eq("t4_cnt_restart", 64'(n), 64'(RI + 1));
        clear_inputs();
        bus.entropy_ack_i = 1'b1;
        bus.entropy_i     = 32'h00000F00;
        tick();
        clear_inputs();

        // Manual reseed not queued; seed + ack together
        bus.reseed_i = 1'b1; tick();
        bus.reseed_i = 1'b1; tick();
        bus.reseed_i = 1'b0; tick();
        bus.reseed_i = 1'b1; tick();
        clear_inputs();
        check_eq("t5_in_req", 64'(bus.entropy_req_o), 64'h1);
        bus.seed_valid_i  = 1'b1;
        bus.seed_i        = 32'hA5A50F0F;
        bus.entropy_ack_i = 1'b1;
        bus.entropy_i     = $urandom;
        tick();
        clear_inputs();
        check_eq("t5_seed_wins", 64'(bus.lfsr_o), 64'hA5A50F0F);
        check_eq("t5_idle", 64'(bus.entropy_req_o), 64'h0);
        tick();
        tick();
        check_eq("t5_no_queue", 64'(bus.entropy_req_o), 64'h0);

        // Asynchronous reset while requesting
        bus.reseed_i = 1'b1; tick();
        clear_inputs();
        bus.en_i = 1'b1; tick(); tick();
        clear_inputs();
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        model_reset();
        check_eq("t6_req_async", 64'(bus.entropy_req_o), 64'h0);
        check_eq("t6_lfsr_async", 64'(bus.lfsr_o), 64'(DSEED));
        check_eq("t6_busy_async", 64'(bus.busy_o), 64'h0);
        #1 rst_ni = 1'b1;

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            bus.en_i          = ($urandom % 4) != 0;
            bus.seed_valid_i  = ($urandom % 16) == 0;
            bus.seed_i        = (($urandom % 4) == 0) ? 32'h0 : $urandom;
            bus.reseed_i      = ($urandom % 8) == 0;
            bus.entropy_ack_i = ($urandom % 4) == 0;
            bus.entropy_i     = (($urandom % 4) == 0) ? m_state : $urandom;
            tick();
        end
        clear_inputs();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/ibex_lfsr_reseed.md
Name: ibex_lfsr_reseed

Overview:
- Parametrised Galois LFSR for Ibex dummy-instruction insertion and ICache scramble nonce generation.
- Generalises the fixed 32-bit seed/permutation constants of the core into a configurable-width generator.
- Adds software seed load, periodic and on-demand reseeding from an external entropy source over a req/ack handshake, and all-zero lockup recovery.
- Sits beside ibex_cs_registers, which drives the seed; the entropy port connects at the top level.

Parameters:
- LfsrW, 32, state width; legal range 8..64.
- Taps, 32'h80200003, Galois feedback mask, LfsrW bits; bit LfsrW-1 must be set.
- DefaultSeed, 32'hac533bf4, reset and lockup-recovery state, LfsrW bits; must be non-zero.
- ReseedInterval, 1024, number of steps between automatic reseed requests; 0 disables automatic reseeding.
- CntW, 16, width of the step counter; ReseedInterval must be less than 2^CntW.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- en_i  in  1  advance LFSR one step this cycle
- seed_valid_i  in  1  load seed_i this cycle (single-cycle pulse)
- seed_i  in  LfsrW  software seed
- reseed_i  in  1  manual reseed request pulse
- entropy_req_o  out  1  entropy request, held until ack
- entropy_ack_i  in  1  entropy valid, one cycle
- entropy_i  in  LfsrW  entropy data, valid with ack
- lfsr_o  out  LfsrW  current state (see Optional Feature)
- lockup_o  out  1  one-cycle pulse: zero state was replaced by DefaultSeed
- busy_o  out  1  high while in REQ

Behaviour:
- Clock and reset: one clock, clk_i; reset is asynchronous and active-low on rst_ni.
- Reset values:
  - state = DefaultSeed
  - counter = 0
  - FSM = IDLE
  - entropy_req_o = 0, lockup_o = 0, busy_o = 0
- Step operation:
  - If state[0] == 1: next = (state >> 1) ^ Taps.
  - Otherwise: next = state >> 1.
  - lfsr_o reflects the registered state, so a step issued in cycle N is visible in cycle N+1.
- State update priority per cycle: seed_valid_i > (entropy_ack_i while in REQ) > en_i. Only one update happens per cycle.
- Seed load:
  - state <= seed_i; counter <= 0.
  - A seed load in REQ does not cancel the request.
- Reseed merge on ack: state <= state ^ entropy_i, with no step applied in that cycle; counter <= 0.
- Lockup: any candidate new state equal to 0 (from seed or merge) is replaced by DefaultSeed, and lockup_o pulses in the following cycle. Stepping cannot produce 0 from a non-zero state.
- Counter:
  - Increments on each applied step.
  - Saturates at ReseedInterval.
  - Never wraps.
- FSM states: IDLE, REQ.
  - IDLE -> REQ when reseed_i = 1, or when (ReseedInterval != 0 and counter == ReseedInterval).
  - REQ -> IDLE on the cycle entropy_ack_i = 1.
  - entropy_req_o = busy_o = (FSM == REQ), driven from the registered state.
  - entropy_ack_i is ignored in IDLE.
  - reseed_i is ignored while in REQ; no second request is queued.
- Stepping continues while in REQ. When en_i and ack arrive in the same cycle, the step is dropped and the merge wins.
- Simultaneous seed_valid_i and ack: the seed is loaded, the ack is consumed (FSM -> IDLE), and the entropy is discarded.
- Reset during REQ: immediate return to IDLE, entropy_req_o drops asynchronously.

Optional Feature:
- Macro: IBEX_LFSR_PERM_EN.
- Defined: lfsr_o = bit-reverse(state) XOR rotate-left(state, LfsrW/2), registered, so lfsr_o lags state by one cycle; reset value of lfsr_o is that function applied to DefaultSeed.
- Undefined: lfsr_o = state with no added latency. Internal state behaviour is identical in both builds.

Test Plan:
- Reset, then en_i = 1 for one cycle (defaults) -> lfsr_o goes 0xac533bf4 -> 0x56299DFA.
- seed_valid_i with seed_i = 0x00000001, then 3 steps -> 0x80200003, 0xC0300002, 0x60180001.
- seed_valid_i with seed_i = 0 -> state 0xac533bf4 and a one-cycle lockup_o pulse; state = 0x12345678 plus ack with entropy 0x12345678 -> same recovery.
- ReseedInterval = 4, en_i held high -> entropy_req_o rises after the 4th step and steps continue; ack with entropy 0xFFFFFFFF -> state = previous state XOR 0xFFFFFFFF, req drops the next cycle, counter restarts.
- reseed_i pulsed twice while in REQ, then seed_valid_i and ack in the same cycle -> only one request, state = seed_i, FSM returns to IDLE.
- rst_ni asserted mid-REQ without a clock edge -> entropy_req_o = 0 immediately and lfsr_o = DefaultSeed.
